// File: rtl/stream_join.sv
// Joins COUNT valid/ready lanes into one registered output beat, one beat per lane.
// Each lane has a single-entry holding buffer so that skewed lanes are re-aligned.
module stream_join #(
  parameter int WIDTH = 32,
  parameter int COUNT = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [COUNT-1:0]       s_valid,
  output logic [COUNT-1:0]       s_ready,
  input  logic [COUNT*WIDTH-1:0] s_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [COUNT*WIDTH-1:0] m_data
);

  logic [COUNT-1:0]       acc;
  logic [COUNT-1:0]       avail;
  logic                   free;
  logic                   fire;

  logic                   m_valid_q;
  logic                   m_valid_d;
  logic [COUNT*WIDTH-1:0] m_data_q;
  logic [COUNT*WIDTH-1:0] m_data_d;

  assign free = ~m_valid_q | m_ready;
  assign fire = (&avail) & free;

  genvar gi;
  generate
    for (gi = 0; gi < COUNT; gi++) begin : g_lane
      logic             full_q;
      logic             full_d;
      logic [WIDTH-1:0] hold_q;
      logic [WIDTH-1:0] hold_d;
      logic [WIDTH-1:0] lane_in;

      assign lane_in     = s_data[gi*WIDTH +: WIDTH];
      assign s_ready[gi] = ~full_q;
      assign acc[gi]     = s_valid[gi] & ~full_q;
      assign avail[gi]   = full_q | acc[gi];

      // A lane accepted on the firing cycle bypasses its buffer straight into the output.
      assign m_data_d[gi*WIDTH +: WIDTH] = fire ? (full_q ? hold_q : lane_in)
                                                : m_data_q[gi*WIDTH +: WIDTH];

      always_comb begin
        full_d = full_q;
        hold_d = hold_q;
        if (fire) begin
          full_d = 1'b0;
        end else if (acc[gi]) begin
          full_d = 1'b1;
          hold_d = lane_in;
        end
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          full_q <= 1'b0;
          hold_q <= '0;
        end else begin
          full_q <= full_d;
          hold_q <= hold_d;
        end
      end
    end
  endgenerate

  always_comb begin
    m_valid_d = m_valid_q;
    if (fire) begin
      m_valid_d = 1'b1;
    end else if (m_ready) begin
      m_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
    end else begin
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
    end
  end

  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;

endmodule

// File: tb/tb_stream_join.sv
// Bench for stream_join: directed scenarios plus randomized traffic against a lane-zip scoreboard.
`timescale 1ns/1ps
module tb_stream_join;
  localparam int WIDTH = 8;
  localparam int COUNT = 2;
  localparam int BW    = WIDTH * COUNT;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [COUNT-1:0] s_valid = '0;
  logic [COUNT-1:0] s_ready;
  logic [BW-1:0]    s_data = '0;
  logic             m_valid;
  logic             m_ready = 1'b0;
  logic [BW-1:0]    m_data;

  int checks = 0;
  int errors = 0;

  // Scoreboard: accepted beats per lane, zipped into expected output beats.
  logic [WIDTH-1:0] lane_q [COUNT][$];
  logic [BW-1:0]    exp_q[$];
  int               acc_cnt [COUNT];
  int               out_cnt = 0;
  int               hs_total = 0;
  bit               stall_prev = 0;
  logic [BW-1:0]    data_prev = '0;

  always #5 clk = ~clk;

  stream_join #(.WIDTH(WIDTH), .COUNT(COUNT)) dut (
    .clk     (clk),
    .reset   (reset),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: samples at the falling edge, between active edges.
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        for (int i = 0; i < COUNT; i++) begin
          lane_q[i].delete();
          acc_cnt[i] = 0;
        end
        exp_q.delete();
        out_cnt    = 0;
        stall_prev = 0;
      end else begin
        for (int i = 0; i < COUNT; i++) begin
          int buffered;
          buffered = acc_cnt[i] - out_cnt - int'(m_valid);
          chk("lane_occupancy_0_or_1", 64'(buffered inside {0, 1}), 64'd1);
          chk("s_ready_vs_occupancy", 64'(s_ready[i]), 64'(buffered == 0));
        end
        if (stall_prev) begin
          chk("stall_m_valid_stable", 64'(m_valid), 64'd1);
          chk("stall_m_data_stable", 64'(m_data), 64'(data_prev));
        end
        if (m_valid && m_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output_beat: got %0h, expected none at %0t", m_data, $time);
          end else begin
            chk("output_beat", 64'(m_data), 64'(exp_q.pop_front()));
          end
          out_cnt++;
          hs_total++;
        end
        stall_prev = m_valid && !m_ready;
        data_prev  = m_data;
        for (int i = 0; i < COUNT; i++) begin
          if (s_valid[i] && s_ready[i]) begin
            lane_q[i].push_back(s_data[i*WIDTH +: WIDTH]);
            acc_cnt[i]++;
          end
        end
        forever begin
          bit all_have;
          logic [BW-1:0] beat;
          all_have = 1;
          for (int i = 0; i < COUNT; i++) if (lane_q[i].size() == 0) all_have = 0;
          if (!all_have) break;
          beat = '0;
          for (int i = 0; i < COUNT; i++) beat[i*WIDTH +: WIDTH] = lane_q[i].pop_front();
          exp_q.push_back(beat);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  // Stimulus
  initial begin
    logic [COUNT-1:0] took;

    // Reset and idle
    repeat (3) step();
    chk("reset_s_ready", 64'(s_ready), 64'h3);
    chk("reset_m_valid", 64'(m_valid), 64'h0);
    chk("reset_m_data", 64'(m_data), 64'h0);
    reset = 1'b0;
    step();
    chk("idle_s_ready", 64'(s_ready), 64'h3);
    chk("idle_m_valid", 64'(m_valid), 64'h0);

    // Aligned single beat
    m_ready = 1'b1;
    s_valid = 2'b11;
    s_data  = 16'hB2A1;
    step();
    chk("aligned_m_valid", 64'(m_valid), 64'h1);
    chk("aligned_m_data", 64'(m_data), 64'hB2A1);
    s_valid = 2'b00;
    step();
    chk("aligned_drained", 64'(m_valid), 64'h0);

    // Eight back-to-back aligned beats, no bubbles
    for (int k = 0; k < 8; k++) begin
      s_valid = 2'b11;
      s_data  = {8'(8'h40 + k), 8'(8'h10 + k)};
      step();
      chk("stream_m_valid", 64'(m_valid), 64'h1);
      chk("stream_m_data", 64'(m_data), 64'({8'(8'h40 + k), 8'(8'h10 + k)}));
    end
    s_valid = 2'b00;
    step();
    chk("stream_drained", 64'(m_valid), 64'h0);

    // Skew: lane0 at cycle 0, lane1 at cycle 3
    s_valid = 2'b01;
    s_data  = 16'h0011;
    step();
    chk("skew_s_ready_c1", 64'(s_ready), 64'h2);
    chk("skew_m_valid_c1", 64'(m_valid), 64'h0);
    s_valid = 2'b00;
    step();
    chk("skew_s_ready_c2", 64'(s_ready), 64'h2);
    step();
    s_valid = 2'b10;
    s_data  = 16'h2200;
    chk("skew_s_ready_c3", 64'(s_ready), 64'h2);
    step();
    chk("skew_m_valid_c4", 64'(m_valid), 64'h1);
    chk("skew_m_data_c4", 64'(m_data), 64'h2211);
    chk("skew_s_ready_c4", 64'(s_ready), 64'h3);
    s_valid = 2'b00;
    step();

    // Output stall with both lanes streaming
    m_ready = 1'b0;
    s_valid = 2'b11;
    s_data  = 16'h0201;
    step();
    chk("stall_first_m_data", 64'(m_data), 64'h0201);
    chk("stall_first_s_ready", 64'(s_ready), 64'h3);
    s_data = 16'h0403;
    step();
    chk("stall_held_m_data", 64'(m_data), 64'h0201);
    chk("stall_lanes_full", 64'(s_ready), 64'h0);
    s_data = 16'h0605;
    step();
    chk("stall_still_held", 64'(m_data), 64'h0201);
    chk("stall_still_full", 64'(s_ready), 64'h0);
    m_ready = 1'b1;
    step();
    chk("release_beat2", 64'(m_data), 64'h0403);
    chk("release_s_ready", 64'(s_ready), 64'h3);
    step();
    chk("release_beat3", 64'(m_data), 64'h0605);
    chk("release_beat3_valid", 64'(m_valid), 64'h1);
    s_valid = 2'b00;
    step();
    chk("release_drained", 64'(m_valid), 64'h0);

    // Asynchronous reset for half a cycle while beats are in flight
    m_ready = 1'b0;
    s_valid = 2'b11;
    s_data  = 16'h3231;
    step();
    s_data = 16'h3433;
    step();
    s_valid = 2'b00;
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset_m_valid", 64'(m_valid), 64'h0);
    chk("async_reset_s_ready", 64'(s_ready), 64'h3);
    #4;
    reset = 1'b0;
    #1;
    chk("async_reset_m_data", 64'(m_data), 64'h0);
    m_ready = 1'b1;
    step();
    chk("after_reset_no_beat", 64'(m_valid), 64'h0);
    chk("after_reset_s_ready", 64'(s_ready), 64'h3);

    // Randomized traffic with valid held until accepted
    took = '0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      for (int i = 0; i < COUNT; i++) begin
        if (!(s_valid[i] && !took[i])) begin
          s_valid[i] = ($urandom_range(0, 3) != 0);
          s_data[i*WIDTH +: WIDTH] = 8'($urandom);
        end
      end
      m_ready = ($urandom_range(0, 3) != 0);
      took = s_valid & s_ready;
      step();
    end
    s_valid = '0;
    m_ready = 1'b1;
    repeat (5) step();
    chk("drain_expected_empty", 64'(exp_q.size()), 64'h0);
    chk("random_traffic_flowed", 64'(hs_total > 1000), 64'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
